// File: rtl/ahb_slave_regs_if.sv
// AHB-Lite slave-side bus bundle for the register block.
// Latency: none, wires only.
// Backpressure: HREADYOUT from the slave, HREADY is returned by the interconnect.
interface ahb_slave_regs_if #(
   parameter int ADDR_BITS = 32,
   parameter int DATA_BITS = 32
);
   logic                 HSEL;
   logic [ADDR_BITS-1:0] HADDR;
   logic [1:0]           HTRANS;
   logic                 HWRITE;
   logic [2:0]           HSIZE;
   logic [2:0]           HBURST;
   logic [DATA_BITS-1:0] HWDATA;
   logic                 HREADY;
   logic [DATA_BITS-1:0] HRDATA;
   logic                 HREADYOUT;
   logic [1:0]           HRESP;

   // HREADY sits with the master side because the interconnect drives it.
   modport master (
      output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
      input  HRDATA, HREADYOUT, HRESP
   );

   modport slave (
      input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
      output HRDATA, HREADYOUT, HRESP
   );
endinterface

// File: rtl/ahb_slave_regs.sv
// AHB-Lite register bank: NUM_REGS 32-bit registers, the last one a read-only ID.
// Latency: WAIT_STATES stall cycles per OKAY data phase; errors take two cycles.
// Backpressure: HREADYOUT low while waiting or during ERR1; next address taken in the completing cycle.
module ahb_slave_regs #(
   parameter int          ADDR_BITS   = 32,
   parameter int          DATA_BITS   = 32,
   parameter int          NUM_REGS    = 16,
   parameter int          WAIT_STATES = 1,
   parameter logic [31:0] ID_VALUE    = 32'h5A5A_0001
) (
   input logic HCLK,
   input logic HRESETn,
   ahb_slave_regs_if.slave bus
);

   localparam int                   IDX_BITS   = $clog2(NUM_REGS);
   localparam logic [IDX_BITS-1:0]  ID_IDX     = IDX_BITS'(NUM_REGS - 1);
   localparam logic [ADDR_BITS-1:0] ADDR_LIMIT = ADDR_BITS'(NUM_REGS * 4);
   localparam logic [2:0]           WS_LOAD    = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

   typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;

   state_t              state_q, state_d;
   logic [2:0]          wcnt_q, wcnt_d;
   // done_q marks the completing data-phase cycle of an OKAY transfer.
   logic                done_q, done_d;
   logic                latch_en;
   logic [IDX_BITS-1:0] a_idx_q;
   logic [1:0]          a_lane_q;
   logic [1:0]          a_size_q;
   logic                a_write_q;
   logic [DATA_BITS-1:0] regs_q [NUM_REGS];

   logic                accept;
   logic                req_err;
   logic                hready_o;
   logic [1:0]          hresp_o;
   logic [3:0]          byte_en;
   logic                wr_commit;
   logic [DATA_BITS-1:0] rd_word;
   logic                unused_burst;

   // Only IDLE and ERR2 present HREADYOUT=1, so only they can take an address phase.
   assign accept  = bus.HSEL & bus.HTRANS[1] & bus.HREADY & ((state_q == IDLE) | (state_q == ERR2));
   assign req_err = (bus.HADDR >= ADDR_LIMIT)
                  | (bus.HSIZE > 3'b010)
                  | ((bus.HSIZE == 3'b001) & bus.HADDR[0])
                  | ((bus.HSIZE == 3'b010) & (bus.HADDR[1:0] != 2'b00));

   // Burst type carries no meaning here; every beat is decoded on its own.
   assign unused_burst = ^bus.HBURST;

   // Next-state, wait counter and bus response for the current data phase.
   always_comb begin
      state_d  = state_q;
      wcnt_d   = wcnt_q;
      done_d   = 1'b0;
      latch_en = 1'b0;
      hready_o = 1'b1;
      hresp_o  = 2'b00;
      case (state_q)
         IDLE, ERR2: begin
            if (state_q == ERR2) hresp_o = 2'b01;
            state_d = IDLE;
            if (accept) begin
               latch_en = 1'b1;
               if (req_err) begin
                  state_d = ERR1;
               end else if (WAIT_STATES == 0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = WAIT;
                  wcnt_d  = WS_LOAD;
               end
            end
         end
         WAIT: begin
            hready_o = 1'b0;
            if (wcnt_q == 3'd0) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               wcnt_d = wcnt_q - 3'd1;
            end
         end
         ERR1: begin
            hready_o = 1'b0;
            hresp_o  = 2'b01;
            state_d  = ERR2;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control state and the latched address-phase attributes.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q   <= IDLE;
         wcnt_q    <= 3'd0;
         done_q    <= 1'b0;
         a_idx_q   <= '0;
         a_lane_q  <= 2'b00;
         a_size_q  <= 2'b00;
         a_write_q <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         done_q  <= done_d;
         if (latch_en) begin
            a_idx_q   <= bus.HADDR[IDX_BITS+1:2];
            a_lane_q  <= bus.HADDR[1:0];
            a_size_q  <= bus.HSIZE[1:0];
            a_write_q <= bus.HWRITE;
         end
      end
   end

   // Little-endian byte lanes touched by the transfer in its data phase.
   always_comb begin
      byte_en = 4'b1111;
      case (a_size_q)
         2'b00:   byte_en = 4'b0001 << a_lane_q;
         2'b01:   byte_en = a_lane_q[1] ? 4'b1100 : 4'b0011;
         default: byte_en = 4'b1111;
      endcase
   end

   // HWDATA is valid in the completing cycle, so the write lands on the edge ending it.
   assign wr_commit = done_q & a_write_q & (a_idx_q != ID_IDX);

   // Register storage; the ID slot is never written and reads back ID_VALUE.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else if (wr_commit) begin
         for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) regs_q[a_idx_q][8*b +: 8] <= bus.HWDATA[8*b +: 8];
         end
      end
   end

   assign rd_word       = (a_idx_q == ID_IDX) ? ID_VALUE : regs_q[a_idx_q];
   assign bus.HRDATA    = (done_q & ~a_write_q) ? rd_word : '0;
   assign bus.HREADYOUT = hready_o;
   assign bus.HRESP     = hresp_o;

endmodule

// File: tb/tb_ahb_slave_regs.sv
// Bench for ahb_slave_regs: two instances (WAIT_STATES 1 and 0) driven by one pipelined master.
// Latency: each beat is checked cycle by cycle against a register-array reference model.
// Backpressure: the master holds its address phase while the selected slave drives HREADYOUT low.
module tb_ahb_slave_regs;
   localparam logic [31:0] ID_VAL = 32'h5A5A_0001;

   typedef struct {
      logic        act;
      logic        sel;
      logic [1:0]  trans;
      logic        wr;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [31:0] wdata;
   } beat_t;

   logic hclk = 1'b0;
   logic hresetn;
   always #5 hclk = ~hclk;

   int checks = 0;
   int errors = 0;

   logic        dsel;
   logic        m_hsel;
   logic [31:0] m_haddr;
   logic [1:0]  m_htrans;
   logic        m_hwrite;
   logic [2:0]  m_hsize;
   logic [2:0]  m_hburst;
   logic [31:0] m_hwdata;
   logic        s_rdy;
   logic [1:0]  s_resp;
   logic [31:0] s_rdata;

   beat_t       q[$];
   logic [31:0] mem [0:1][0:15];
   logic [31:0] last_rdata;

   ahb_slave_regs_if #(.ADDR_BITS(32), .DATA_BITS(32)) b0 ();
   ahb_slave_regs_if #(.ADDR_BITS(32), .DATA_BITS(32)) b1 ();

   assign b0.HSEL   = m_hsel & ~dsel;
   assign b1.HSEL   = m_hsel & dsel;
   assign b0.HADDR  = m_haddr;   assign b1.HADDR  = m_haddr;
   assign b0.HTRANS = m_htrans;  assign b1.HTRANS = m_htrans;
   assign b0.HWRITE = m_hwrite;  assign b1.HWRITE = m_hwrite;
   assign b0.HSIZE  = m_hsize;   assign b1.HSIZE  = m_hsize;
   assign b0.HBURST = m_hburst;  assign b1.HBURST = m_hburst;
   assign b0.HWDATA = m_hwdata;  assign b1.HWDATA = m_hwdata;
   assign b0.HREADY = b0.HREADYOUT;
   assign b1.HREADY = b1.HREADYOUT;

   assign s_rdy   = dsel ? b1.HREADYOUT : b0.HREADYOUT;
   assign s_resp  = dsel ? b1.HRESP     : b0.HRESP;
   assign s_rdata = dsel ? b1.HRDATA    : b0.HRDATA;

   ahb_slave_regs #(.WAIT_STATES(0)) u_dut0 (.HCLK(hclk), .HRESETn(hresetn), .bus(b0));
   ahb_slave_regs #(.WAIT_STATES(1)) u_dut1 (.HCLK(hclk), .HRESETn(hresetn), .bus(b1));

   // ---------------- reference model ----------------
   function automatic bit model_err(input logic [31:0] addr, input logic [2:0] size);
      return (addr >= 32'd64) || (size > 3'd2) ||
             (size == 3'd1 && addr[0]) || (size == 3'd2 && addr[1:0] != 2'b00);
   endfunction

   function automatic logic [31:0] model_read(input int d, input logic [31:0] addr);
      int idx;
      idx = int'(addr[5:2]);
      return (idx == 15) ? ID_VAL : mem[d][idx];
   endfunction

   task automatic model_write(input int d, input logic [31:0] addr, input logic [2:0] size,
                              input logic [31:0] wdata);
      int  idx;
      bit  en;
      idx = int'(addr[5:2]);
      if (idx == 15) return;
      for (int b = 0; b < 4; b++) begin
         en = (size == 3'd2) || (size == 3'd1 && (b / 2) == int'(addr[1])) ||
              (size == 3'd0 && b == int'(addr[1:0]));
         if (en) mem[d][idx][8*b +: 8] = wdata[8*b +: 8];
      end
   endtask

   task automatic model_clear();
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 16; i++) mem[d][i] = 32'h0;
   endtask

   function automatic beat_t mk(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                                input logic [31:0] wdata);
      beat_t bt;
      bt.act = 1'b1; bt.sel = 1'b1; bt.trans = 2'b10;
      bt.wr = wr; bt.addr = addr; bt.size = size; bt.wdata = wdata;
      return bt;
   endfunction

   // Pipelined master: entered and left just after a rising edge with the slave idle.
   task automatic run_beats(input string tag, output int cycles);
      beat_t       dp;
      bit          dp_vld, stop, err;
      int          k, idx, nc, ws, d;
      logic        o_rdy, e_rdy;
      logic [1:0]  o_resp, e_resp;
      logic [31:0] o_rdata, e_rdata;
      dp = mk(1'b0, 32'h0, 3'd0, 32'h0);
      dp_vld = 0; stop = 0; err = 0; k = 0; idx = 0; cycles = 0;
      d  = dsel ? 1 : 0;
      ws = dsel ? 1 : 0;
      while (!stop && (idx < q.size() || dp_vld)) begin
         cycles++;
         if (idx < q.size()) begin
            m_hsel = q[idx].sel; m_htrans = q[idx].trans; m_hwrite = q[idx].wr;
            m_haddr = q[idx].addr; m_hsize = q[idx].size;
         end else begin
            m_hsel = 1'b0; m_htrans = 2'b00; m_hwrite = 1'b0;
            m_haddr = $urandom; m_hsize = 3'd2;
         end
         m_hburst = 3'($urandom_range(0, 7));
         m_hwdata = (dp_vld && dp.wr) ? dp.wdata : $urandom;
         @(negedge hclk);
         o_rdy = s_rdy; o_resp = s_resp; o_rdata = s_rdata;
         if (dp_vld) begin
            err     = dp.act && model_err(dp.addr, dp.size);
            nc      = !dp.act ? 1 : (err ? 2 : ws + 1);
            e_rdy   = (k == nc - 1);
            e_resp  = err ? 2'b01 : 2'b00;
            e_rdata = (dp.act && !err && !dp.wr && k == nc - 1) ? model_read(d, dp.addr) : 32'h0;
            checks++;
            if (o_rdy !== e_rdy || o_resp !== e_resp || o_rdata !== e_rdata) begin
               errors++;
               $display("FAIL %s beat %0d cycle %0d (wr=%0d addr=%h size=%0d): got rdy=%b resp=%b rdata=%h, expected rdy=%b resp=%b rdata=%h",
                        tag, idx - 1, k, dp.wr, dp.addr, dp.size, o_rdy, o_resp, o_rdata, e_rdy, e_resp, e_rdata);
            end
         end
         @(posedge hclk); #1;
         if (o_rdy === 1'b1) begin
            if (dp_vld && dp.act && !err) begin
               if (dp.wr) model_write(d, dp.addr, dp.size, dp.wdata);
               else       last_rdata = o_rdata;
            end
            if (idx < q.size()) begin
               dp = q[idx]; dp_vld = 1; idx++;
            end else begin
               dp_vld = 0;
            end
            k = 0;
         end else begin
            k++;
            if (k > 16) begin
               errors++;
               $display("FAIL %s timeout: HREADYOUT stuck at %b, expected 1 within 16 cycles", tag, o_rdy);
               stop = 1;
            end
         end
      end
      m_hsel = 1'b0; m_htrans = 2'b00;
      q.delete();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      hresetn = 1'b0;
      #12;
      checks++;
      if (b0.HREADYOUT !== 1'b1 || b0.HRESP !== 2'b00 || b0.HRDATA !== 32'h0) begin
         errors++;
         $display("FAIL reset_ws0: got rdy=%b resp=%b rdata=%h, expected 1 00 00000000", b0.HREADYOUT, b0.HRESP, b0.HRDATA);
      end
      checks++;
      if (b1.HREADYOUT !== 1'b1 || b1.HRESP !== 2'b00 || b1.HRDATA !== 32'h0) begin
         errors++;
         $display("FAIL reset_ws1: got rdy=%b resp=%b rdata=%h, expected 1 00 00000000", b1.HREADYOUT, b1.HRESP, b1.HRDATA);
      end
      @(posedge hclk); #1;
      hresetn = 1'b1;
   endtask

   task automatic test_lanes();
      int cyc;
      dsel = 1'b1;
      q.push_back(mk(1'b1, 32'h04, 3'd2, 32'hDEADBEEF));
      q.push_back(mk(1'b0, 32'h04, 3'd2, 32'h0));
      run_beats("word_wr_rd", cyc);
      checks++;
      if (last_rdata !== 32'hDEADBEEF) begin
         errors++; $display("FAIL word_rd_value: got %h, expected DEADBEEF", last_rdata);
      end
      checks++;
      if (cyc !== 5) begin
         errors++; $display("FAIL word_ws1_cycles: got %0d, expected 5", cyc);
      end
      q.push_back(mk(1'b1, 32'h05, 3'd0, 32'h0000_1100));
      q.push_back(mk(1'b1, 32'h06, 3'd1, 32'h2233_0000));
      q.push_back(mk(1'b0, 32'h04, 3'd2, 32'h0));
      run_beats("byte_half", cyc);
      checks++;
      if (last_rdata !== 32'h2233_11EF) begin
         errors++; $display("FAIL byte_half_value: got %h, expected 223311EF", last_rdata);
      end
   endtask

   task automatic test_errors();
      int cyc;
      dsel = 1'b1;
      q.push_back(mk(1'b0, 32'h40, 3'd2, 32'h0));
      q.push_back(mk(1'b1, 32'h02, 3'd2, 32'hFFFF_FFFF));
      q.push_back(mk(1'b1, 32'h01, 3'd1, 32'hFFFF_FFFF));
      q.push_back(mk(1'b1, 32'h00, 3'd3, 32'hFFFF_FFFF));
      q.push_back(mk(1'b0, 32'h00, 3'd2, 32'h0));
      run_beats("errors", cyc);
      checks++;
      if (last_rdata !== 32'h0) begin
         errors++; $display("FAIL err_no_write: got %h, expected 00000000", last_rdata);
      end
      checks++;
      if (cyc !== 11) begin
         errors++; $display("FAIL err_cycles: got %0d, expected 11", cyc);
      end
   endtask

   task automatic test_id();
      int cyc;
      dsel = 1'b1;
      q.push_back(mk(1'b1, 32'h3C, 3'd2, 32'hFFFF_FFFF));
      q.push_back(mk(1'b0, 32'h3C, 3'd2, 32'h0));
      run_beats("id_reg", cyc);
      checks++;
      if (last_rdata !== ID_VAL) begin
         errors++; $display("FAIL id_value: got %h, expected %h", last_rdata, ID_VAL);
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      dsel = 1'b0;
      q.push_back(mk(1'b1, 32'h08, 3'd2, 32'hCAFE_0001));
      q.push_back(mk(1'b0, 32'h08, 3'd2, 32'h0));
      run_beats("b2b_ws0", cyc);
      checks++;
      if (last_rdata !== 32'hCAFE_0001) begin
         errors++; $display("FAIL b2b_value: got %h, expected CAFE0001", last_rdata);
      end
      checks++;
      if (cyc !== 3) begin
         errors++; $display("FAIL b2b_cycles: got %0d, expected 3", cyc);
      end
   endtask

   task automatic test_random();
      beat_t bt;
      int    cyc, s;
      for (int d = 0; d < 2; d++) begin
         dsel = d[0];
         for (int n = 0; n < 120; n++) begin
            bt = mk(1'($urandom_range(0, 1)), 32'h0, 3'd0, $urandom);
            bt.trans = 2'($urandom_range(2, 3));
            s = $urandom_range(0, 15);
            bt.size = (s < 5) ? 3'd0 : (s < 10) ? 3'd1 : (s < 15) ? 3'd2 : 3'($urandom_range(3, 7));
            if ($urandom_range(0, 3) != 0)
               bt.addr = 32'($urandom_range(0, 15) * 4 +
                             ((bt.size == 3'd0) ? $urandom_range(0, 3) :
                              (bt.size == 3'd1) ? 2 * $urandom_range(0, 1) : 0));
            else
               bt.addr = 32'($urandom_range(0, 80));
            if ($urandom_range(0, 9) < 2) begin
               bt.act = 1'b0;
               if ($urandom_range(0, 1) == 1) bt.sel = 1'b0;
               else bt.trans = 2'($urandom_range(0, 1));
            end
            q.push_back(bt);
         end
         run_beats(d == 0 ? "random_ws0" : "random_ws1", cyc);
      end
   endtask

   task automatic test_reset_mid();
      int cyc;
      dsel = 1'b1;
      m_hsel = 1'b1; m_htrans = 2'b10; m_hwrite = 1'b1; m_haddr = 32'h0; m_hsize = 3'd2;
      @(posedge hclk); #1;
      m_hsel = 1'b0; m_htrans = 2'b00; m_hwdata = 32'h1234_5678;
      @(negedge hclk);
      checks++;
      if (b1.HREADYOUT !== 1'b0) begin
         errors++; $display("FAIL midrst_wait: got rdy=%b, expected 0", b1.HREADYOUT);
      end
      #1 hresetn = 1'b0;
      #1;
      checks++;
      if (b1.HREADYOUT !== 1'b1 || b1.HRESP !== 2'b00 || b1.HRDATA !== 32'h0) begin
         errors++;
         $display("FAIL midrst_outputs: got rdy=%b resp=%b rdata=%h, expected 1 00 00000000", b1.HREADYOUT, b1.HRESP, b1.HRDATA);
      end
      model_clear();
      @(posedge hclk); #1;
      hresetn = 1'b1;
      q.push_back(mk(1'b0, 32'h00, 3'd2, 32'h0));
      run_beats("midrst_read", cyc);
      checks++;
      if (last_rdata !== 32'h0) begin
         errors++; $display("FAIL midrst_no_write: got %h, expected 00000000", last_rdata);
      end
   endtask

   initial begin
      dsel = 1'b1; m_hsel = 1'b0; m_haddr = 32'h0; m_htrans = 2'b00; m_hwrite = 1'b0;
      m_hsize = 3'd2; m_hburst = 3'd0; m_hwdata = 32'h0; last_rdata = 32'hFFFF_FFFF;
      model_clear();
      test_reset();
      test_lanes();
      test_errors();
      test_id();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/ahb_slave_regs.md
AHB_SLAVE_REGS -- requirements
Module: ahb_slave_regs

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 32: HADDR width.
REQ-002 SHALL have parameter DATA_BITS, default 32: data bus width; only 32 supported.
REQ-003 SHALL have parameter NUM_REGS, default 16: number of 32-bit registers (power of 2, 2..256).
REQ-004 SHALL have parameter WAIT_STATES, default 1: HREADYOUT-low cycles per OKAY data phase (0..7).
REQ-005 SHALL have parameter ID_VALUE, default 32'h5A5A_0001: read-only contents of register NUM_REGS-1.
REQ-006 SHALL have ports, one clock (HCLK) and asynchronous active-low reset (HRESETn): HCLK in 1 bus clock; HRESETn in 1 async active-low reset; HSEL in 1 slave select; HADDR in ADDR_BITS; HTRANS in 2; HWRITE in 1; HSIZE in 3; HBURST in 3 (ignored); HWDATA in DATA_BITS; HREADY in 1 bus-level ready; HRDATA out DATA_BITS; HREADYOUT out 1; HRESP out 2 (00 OKAY, 01 ERROR).

Function
REQ-007 SHALL accept an address phase only when HSEL=1, HTRANS[1]=1 (NONSEQ/SEQ) and HREADY=1 at a rising HCLK edge; it then latches HADDR, HWRITE, HSIZE.
REQ-008 SHALL treat IDLE/BUSY or HSEL=0 as no transfer: next cycle HREADYOUT=1, HRESP=00, no register change.
REQ-009 SHALL flag a transfer as error if HADDR >= NUM_REGS*4, HSIZE > 3'b010, or HADDR misaligned to HSIZE (halfword addr[0]!=0, word addr[1:0]!=0).
REQ-010 SHALL implement FSM states IDLE, WAIT, ERR1, ERR2.
REQ-011 IDLE: on valid accepted transfer -> WAIT if WAIT_STATES>0, else complete zero-wait (stay IDLE, HREADYOUT=1); on error transfer -> ERR1.
REQ-012 WAIT: counter loaded WAIT_STATES-1 on entry, HREADYOUT=0; at count 0 -> IDLE, following cycle is the completing data-phase cycle (HREADYOUT=1, HRESP=00).
REQ-013 ERR1: HREADYOUT=0, HRESP=01, always -> ERR2; ERR2: HREADYOUT=1, HRESP=01, -> IDLE (or accept new transfer per REQ-007).
REQ-014 SHALL accept a new address phase in the completing data-phase cycle of the previous transfer (pipelined back-to-back, no bubble).
REQ-015 Writes SHALL commit at the rising edge ending the completing data-phase cycle, sampling HWDATA then; error transfers never write.
REQ-016 Byte lanes SHALL be little-endian: byte writes update byte addr[1:0], halfword writes update half addr[1]; other bytes retained.
REQ-017 Reads SHALL drive the full 32-bit register on HRDATA during the completing data-phase cycle; HRDATA=0 in all other cycles, including error responses.
REQ-018 Register NUM_REGS-1 SHALL read ID_VALUE; writes to it complete OKAY and are discarded.
REQ-019 Write then read of the same address back-to-back SHALL return the newly written value.
REQ-020 HBURST SHALL be ignored; each beat is an independent transfer.

Reset
REQ-021 HRESETn low SHALL asynchronously force state IDLE, wait counter 0, all writable registers 0, HREADYOUT=1, HRESP=00, HRDATA=0.
REQ-022 Reset asserted mid-transfer SHALL abort it with no register write; first cycle after deassertion behaves as IDLE.

Verification
REQ-023 Word write 0xDEADBEEF to 0x04, then read 0x04 (WAIT_STATES=1) -> one HREADYOUT-low cycle per transfer, HRESP=00, HRDATA=0xDEADBEEF.
REQ-024 After REQ-023, byte write 0x11 to 0x05 and halfword write 0x2233 to 0x06 -> read 0x04 returns 0x2233_11EF.
REQ-025 Read 0x40 (NUM_REGS=16) and word write to 0x02 -> each gives ERR1 (HREADYOUT=0, HRESP=01) then ERR2 (HREADYOUT=1, HRESP=01); register 0 unchanged.
REQ-026 WAIT_STATES=0: back-to-back NONSEQ write 0xCAFE0001 to 0x08 then read 0x08 -> both complete zero-wait, read returns 0xCAFE0001.
REQ-027 Write 0xFFFFFFFF to 0x3C -> OKAY; read 0x3C returns 0x5A5A0001.
REQ-028 Assert HRESETn low during WAIT of write 0x12345678 to 0x00 -> HREADYOUT=1 immediately; after release read 0x00 returns 0x00000000.
